serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
- Upstream feeder for the bit-serial adder.
- Accepts operand pairs over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Drives the adder's load/start/A/B sequence for one pair at a time, waits for done, captures sum and presents it on a valid/ready result port.
- Sits between the operand source and the bit_serial_adder instance.

Parameters:
- WIDTH, 4, operand/sum width; matches adder A/B/sum.
- DEPTH, 4, operand FIFO entries; power of two, >= 2.
- TIMEOUT, 16, max cycles in WAIT before abort; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  FIFO can accept; = !full.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- load  out  1  to adder; one-cycle pulse, A/B valid.
- start  out  1  to adder; one-cycle pulse after load.
- A  out  WIDTH  to adder, operand A.
- B  out  WIDTH  to adder, operand B.
- sum  in  WIDTH  from adder; result.
- done  in  1  from adder; result valid.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  captured sum.
- res_err  out  1  result aborted by timeout; constant 0 without SEQ_TIMEOUT_EN.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - load=0, start=0, A=0, B=0, res_valid=0, res_sum=0, res_err=0, fifo_count=0, busy=0.
  - FIFO emptied, FSM=IDLE; op_ready=1 after reset.
  - Reset mid-operation discards the in-flight pair and all queued pairs; no result is emitted.
- FIFO:
  - Push on op_valid&&op_ready.
  - Pop only on IDLE->LOAD.
  - Same-cycle push+pop leaves count unchanged.
  - When full, op_ready=0; no bypass, so a pop in that cycle does not raise op_ready until the next cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT, OUT.
  - IDLE: if count>0, pop head into A/B registers, go LOAD; else stay.
  - LOAD: load=1 for exactly this cycle, A/B stable; go START.
  - START: start=1 for exactly this cycle; go WAIT.
  - WAIT: done sampled only in this state. On done=1, capture sum into res_sum, set res_valid=1, go OUT.
  - OUT: res_valid held with res_sum/res_err stable until res_ready=1. On that edge res_valid=0, go IDLE.
- Handshake rules:
  - load and start are never high simultaneously.
  - done outside WAIT is ignored.
  - A/B hold their value from LOAD until the next pop.
- Latency:
  - Pair pushed into an empty FIFO while IDLE: popped the next cycle, load the cycle after, start one cycle later.
  - Result latency = adder latency + 4 cycles from push to res_valid.
- Arithmetic: res_sum = sum as delivered, WIDTH bits, carry discarded (mod 2^WIDTH).
- Throughput: one pair per (adder latency + 4 + result stall) cycles; no overlap of pairs.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If done is not seen within TIMEOUT cycles, go OUT with res_valid=1, res_sum=0, res_err=1.
  - res_err clears when the result is accepted.
  - A late done is ignored, since the FSM is no longer in WAIT.
- SEQ_TIMEOUT_EN not defined:
  - No counter; WAIT waits indefinitely.
  - res_err is tied to 0.

Test Plan:
- Reset, push (3,4), res_ready=1 -> load pulse with A=3,B=4, start pulse next cycle, then res_valid=1, res_sum=7, res_err=0, one pulse each.
- Push (9,9) -> res_sum=2 (wrap mod 16); push (15,1) -> res_sum=0.
- res_ready=0, push pairs continuously -> first pair popped, then 4 more accepted (fifo_count=4). op_ready=0 after the 5th accept. Release res_ready -> results emitted in push order, op_ready reasserts.
- Assert rst_n=0 during WAIT with 2 pairs queued -> all outputs zero immediately, fifo_count=0, no res_valid after release.
- Force done=1 during IDLE/LOAD/START -> no capture; capture occurs only once WAIT is reached.
- With SEQ_TIMEOUT_EN, hold done=0 -> exactly TIMEOUT cycles after entering WAIT, res_valid=1, res_err=1, res_sum=0. The next pair then completes normally with res_err=0.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: buffers operand pairs in a FIFO and drives one bit-serial add at a time.
// Optional macro SEQ_TIMEOUT_EN aborts a WAIT that outlasts TIMEOUT cycles with res_err=1.
module serial_add_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  output logic                     load,
  output logic                     start,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("serial_add_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  state_t          r_state, w_next;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [WIDTH-1:0] r_a, r_b, r_res_sum;
  logic            w_push, w_pop, w_tmo;

  // op_ready comes from the registered count only, so a pop never frees a slot in the same cycle
  assign op_ready   = r_count != (AW+1)'(DEPTH);
  assign w_push     = op_valid && op_ready;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign fifo_count = r_count;
  assign load       = r_state == LOAD;
  assign start      = r_state == START;
  assign res_valid  = r_state == OUT;
  assign busy       = r_state != IDLE;
  assign A          = r_a;
  assign B          = r_b;
  assign res_sum    = r_res_sum;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= op_a;
      r_mem_b[r_wr_ptr] <= op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? LOAD : IDLE;
      LOAD:    w_next = START;
      START:   w_next = WAIT;
      WAIT:    w_next = (done || w_tmo) ? OUT : WAIT;
      OUT:     w_next = res_ready ? IDLE : OUT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res_sum <= '0;
    end else begin
      if (w_pop) begin
        r_a <= r_mem_a[r_rd_ptr];
        r_b <= r_mem_b[r_rd_ptr];
      end
      if (r_state == WAIT && done) r_res_sum <= sum;
      else if (r_state == WAIT && w_tmo) r_res_sum <= '0;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_res_err;

  // r_tmo counts completed WAIT cycles; the abort lands exactly TIMEOUT edges after entering WAIT
  assign w_tmo   = (r_state == WAIT) && (r_tmo == TW'(TIMEOUT - 1));
  assign res_err = r_res_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo     <= '0;
      r_res_err <= 1'b0;
    end else begin
      r_tmo <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
      if (r_state == WAIT && done) r_res_err <= 1'b0;
      else if (w_tmo) r_res_err <= 1'b1;
      else if (r_state == OUT && res_ready) r_res_err <= 1'b0;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed vectors against a behavioural bit-serial adder stand-in.
module tb_serial_add_sequencer;
  localparam int WIDTH = 4, DEPTH = 4, TIMEOUT = 16;

  logic             clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic             op_ready, load, start, done, res_valid, res_err, busy;
  logic [WIDTH-1:0] A, B, sum, res_sum;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0, failures = 0;
  int lat = 3;
  logic force_done = 1'b0;
  logic [WIDTH-1:0] m_sum;
  int m_cnt;

  serial_add_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .load(load), .start(start), .A(A), .B(B),
    .sum(sum), .done(done), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_err(res_err), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // adder stand-in: result ready lat cycles after start; lat=0 means it never answers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_sum <= '0;
    end else if (start) begin
      m_sum <= A + B;
      m_cnt <= lat;
    end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
  end
  assign done = (m_cnt == 1) || force_done;
  assign sum  = m_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (res_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic run_pair(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp);
    bit ok;
    push_one(a, b);
    wait_res(ok);
    check({tag, "_seen"}, 32'(ok), 1);
    check({tag, "_sum"}, 32'(res_sum), 32'(exp));
    check({tag, "_err"}, 32'(res_err), 0);
    tick();
    check({tag, "_drop"}, 32'(res_valid), 0);
  endtask

  logic [WIDTH-1:0] fa [5] = '{4'd1, 4'd7, 4'd12, 4'd8, 4'd15};
  logic [WIDTH-1:0] fb [5] = '{4'd2, 4'd7, 4'd5, 4'd8, 4'd15};
  logic [WIDTH-1:0] fs [5] = '{4'd3, 4'd14, 4'd1, 4'd0, 4'd14};

  initial begin
    bit ok;
    int acc, k, n;
    logic rdy;
    tick();
    tick();
    check("rst_load", 32'(load), 0);
    check("rst_start", 32'(start), 0);
    check("rst_ab", 32'({A, B}), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_sum", 32'(res_sum), 0);
    check("rst_res_err", 32'(res_err), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_ready", 32'(op_ready), 1);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    push_one(4'd3, 4'd4);
    check("p1_count", 32'(fifo_count), 1);
    check("p1_idle_load", 32'(load), 0);
    tick();
    check("p1_load", 32'(load), 1);
    check("p1_load_start", 32'(start), 0);
    check("p1_A", 32'(A), 3);
    check("p1_B", 32'(B), 4);
    check("p1_popped", 32'(fifo_count), 0);
    tick();
    check("p1_start", 32'(start), 1);
    check("p1_start_load", 32'(load), 0);
    check("p1_hold_A", 32'(A), 3);
    wait_res(ok);
    check("p1_seen", 32'(ok), 1);
    check("p1_sum", 32'(res_sum), 7);
    check("p1_err", 32'(res_err), 0);
    tick();
    check("p1_drop", 32'(res_valid), 0);

    run_pair("wrap9", 4'd9, 4'd9, 4'd2);
    run_pair("wrap15", 4'd15, 4'd1, 4'd0);

    res_ready = 1'b0;
    acc = 0;
    op_valid = 1'b1;
    op_a = fa[0];
    op_b = fb[0];
    for (int c = 0; c < 40 && acc < 5; c++) begin
      rdy = op_ready;
      tick();
      if (rdy) begin
        acc++;
        if (acc < 5) begin
          op_a = fa[acc];
          op_b = fb[acc];
        end
      end
    end
    op_valid = 1'b0;
    check("full_accepts", acc, 5);
    check("full_count", 32'(fifo_count), 4);
    check("full_ready", 32'(op_ready), 0);
    for (int c = 0; c < 8; c++) tick();
    check("stall_ready", 32'(op_ready), 0);
    check("stall_count", 32'(fifo_count), 4);
    check("stall_valid", 32'(res_valid), 1);
    check("stall_sum", 32'(res_sum), 3);
    res_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 150 && k < 5; c++) begin
      if (res_valid) begin
        check($sformatf("order%0d", k), 32'(res_sum), 32'(fs[k]));
        k++;
      end
      tick();
    end
    check("order_all", k, 5);
    check("drain_ready", 32'(op_ready), 1);
    check("drain_count", 32'(fifo_count), 0);

    lat = 20;
    op_valid = 1'b1;
    op_a = 4'd1;
    op_b = 4'd1;
    tick();
    tick();
    tick();
    op_valid = 1'b0;
    for (int c = 0; c < 20 && !start; c++) tick();
    check("mid_start_seen", 32'(start), 1);
    tick();
    check("mid_queued", 32'(fifo_count), 2);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ab", 32'({A, B}), 0);
    check("mid_rst_ctl", 32'({load, start, res_valid, res_err}), 0);
    check("mid_rst_ready", 32'(op_ready), 1);
    tick();
    rst_n = 1'b1;
    lat = 3;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (res_valid || load) n++;
      tick();
    end
    check("mid_no_result", n, 0);

    force_done = 1'b1;
    push_one(4'd5, 4'd6);
    check("fd_idle", 32'(res_valid), 0);
    tick();
    check("fd_load", 32'({load, res_valid}), 2);
    tick();
    check("fd_start", 32'({start, res_valid}), 2);
    tick();
    check("fd_wait", 32'(res_valid), 0);
    tick();
    check("fd_capture", 32'(res_valid), 1);
    check("fd_sum", 32'(res_sum), 11);
    force_done = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (res_valid) n++;
    end
    check("fd_late_done", n, 0);

`ifdef SEQ_TIMEOUT_EN
    lat = 0;
    push_one(4'd2, 4'd3);
    for (int c = 0; c < 20 && !start; c++) tick();
    check("to_start_seen", 32'(start), 1);
    n = 0;
    for (int c = 0; c < 60 && !res_valid; c++) begin
      tick();
      n++;
    end
    check("to_cycles", n, TIMEOUT + 1);
    check("to_err", 32'(res_err), 1);
    check("to_sum", 32'(res_sum), 0);
    tick();
    lat = 3;
    run_pair("after_to", 4'd6, 4'd7, 4'd13);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
